bit_insertion_4x8_seq: RTL and testbench

//  Inverse of the 8x4 bit selection stage: deposits a 4-bit chunk into an 8-bit word at a commanded offset.

---
 rtl/bit_insertion_4x8_seq_pkg.sv | 35 +++
 rtl/bit_insertion_4x8_comb.sv | 31 +++
 rtl/bit_insertion_4x8_seq.sv | 76 +++++++
 tb/tb_bit_insertion_4x8_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_insertion_4x8_seq_pkg.sv
// Shared encoding for the 4<->8 bit insertion/selection path: command layout,
// widths and the shift decode that both directions must agree on.
package bit_insertion_4x8_seq_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int IN_DATA_WIDTH = DATA_WIDTH >> 1;
    localparam int COMMAND_WIDTH = $clog2(DATA_WIDTH);

    localparam int CMD_SHIFT_EN_BIT = 2;
    localparam int CMD_OFFSET_LSB   = 0;
    localparam int CMD_OFFSET_W     = 2;

    // Shift amounts span 0..4, so three bits are enough.
    localparam int SHIFT_W = 3;

    typedef logic [SHIFT_W-1:0] shift_t;

    // Partially assembled word: data, written-bit mask and sticky overlap flag.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] mask;
        logic                  ovl;
    } asm_t;

    function automatic shift_t decode_shift(input logic [COMMAND_WIDTH-1:0] cmd);
        shift_t sh;
        if (cmd[CMD_SHIFT_EN_BIT]) begin
            sh = SHIFT_W'(cmd[CMD_OFFSET_LSB +: CMD_OFFSET_W]) + SHIFT_W'(1);
        end else begin
            sh = '0;
        end
        return sh;
    endfunction

endpackage

// File: rtl/bit_insertion_4x8_comb.sv
// Places a 4-bit chunk into an 8-bit lane at the commanded offset and
// reports which lane bits the chunk covers.
module bit_insertion_4x8_comb
    import bit_insertion_4x8_seq_pkg::*;
(
    input  logic [IN_DATA_WIDTH-1:0] chunk,
    input  logic [COMMAND_WIDTH-1:0] cmd,
    output logic [DATA_WIDTH-1:0]    data_shifted,
    output logic [DATA_WIDTH-1:0]    chunk_mask
);

    shift_t     sh;
    logic [3:0] sh_ext;

    assign sh     = decode_shift(cmd);
    assign sh_ext = {1'b0, sh};

    // Each output bit picks chunk bit (gi - sh) when it falls inside the window.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_lane
            logic [3:0] rel;
            logic       in_window;

            assign rel             = 4'(gi) - sh_ext;
            assign in_window       = (sh_ext <= 4'(gi)) && (4'(gi) < (sh_ext + 4'd4));
            assign chunk_mask[gi]  = in_window;
            assign data_shifted[gi] = in_window & chunk[rel[1:0]];
        end
    endgenerate

endmodule

// File: rtl/bit_insertion_4x8_seq.sv
// Accumulates 4-bit chunks into an 8-bit word over one or more beats and
// emits the finished word, its written-bit mask and an overlap flag one cycle after the last beat.
module bit_insertion_4x8_seq
    import bit_insertion_4x8_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic [IN_DATA_WIDTH-1:0] i_data_bus,
    input  logic [COMMAND_WIDTH-1:0] i_cmd,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data_bus,
    output logic [DATA_WIDTH-1:0]    o_mask,
    output logic                     o_overlap
);

    logic [DATA_WIDTH-1:0] data_shifted;
    logic [DATA_WIDTH-1:0] chunk_mask;

    asm_t asm_reg, asm_next;
    asm_t merged;
    asm_t out_reg, out_next;
    logic out_valid_reg, out_valid_next;
    logic accept;

    bit_insertion_4x8_comb u_comb (
        .chunk        (i_data_bus),
        .cmd          (i_cmd),
        .data_shifted (data_shifted),
        .chunk_mask   (chunk_mask)
    );

    assign accept = i_en & i_valid;

    // Later beats overwrite earlier ones; any re-written bit sets the sticky overlap.
    always_comb begin
        merged.data = (asm_reg.data & ~chunk_mask) | data_shifted;
        merged.mask = asm_reg.mask | chunk_mask;
        merged.ovl  = asm_reg.ovl | (|(asm_reg.mask & chunk_mask));
    end

    always_comb begin
        asm_next       = asm_reg;
        out_next       = '0;
        out_valid_next = 1'b0;
        if (accept) begin
            if (i_last) begin
                out_next       = merged;
                out_valid_next = 1'b1;
                asm_next       = '0;
            end else begin
                asm_next = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            asm_reg       <= asm_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign o_valid    = out_valid_reg;
    assign o_data_bus = out_reg.data;
    assign o_mask     = out_reg.mask;
    assign o_overlap  = out_reg.ovl;

endmodule

// File: tb/tb_bit_insertion_4x8_seq.sv
// Directed bench for bit_insertion_4x8_seq: a per-bit behavioural model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_bit_insertion_4x8_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en, i_valid, i_last;
    logic [3:0] i_data_bus;
    logic [2:0] i_cmd;
    logic       o_valid;
    logic [7:0] o_data_bus, o_mask;
    logic       o_overlap;

    int total = 0;
    int bad   = 0;

    bit_insertion_4x8_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_last     (i_last),
        .i_data_bus (i_data_bus),
        .i_cmd      (i_cmd),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_mask     (o_mask),
        .o_overlap  (o_overlap)
    );

    always #5 clk = ~clk;

    // Model state: per-bit value and written flags for the word being built.
    typedef struct packed {
        logic [7:0] val;
        logic [7:0] wr;
        logic       ovl;
    } mstate_t;

    mstate_t     ms;
    logic [17:0] exp_out;
    logic [17:0] dut_out;

    assign dut_out = {o_valid, o_data_bus, o_mask, o_overlap};

    function automatic mstate_t model_step(input mstate_t s, input logic [3:0] chunk,
                                           input logic [2:0] cmd);
        mstate_t n;
        int      sh;
        n  = s;
        sh = cmd[2] ? int'(cmd[1:0]) + 1 : 0;
        for (int b = 0; b < 8; b++) begin
            if (b >= sh && b < sh + 4) begin
                if (n.wr[b]) n.ovl = 1'b1;
                n.wr[b]  = 1'b1;
                n.val[b] = chunk[b - sh];
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms      <= '0;
            exp_out <= '0;
        end else if (i_en && i_valid) begin
            if (i_last) begin
                exp_out <= {1'b1, model_step(ms, i_data_bus, i_cmd)};
                ms      <= '0;
            end else begin
                ms      <= model_step(ms, i_data_bus, i_cmd);
                exp_out <= '0;
            end
        end else begin
            exp_out <= '0;
        end
    end

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got v=%0b d=%h m=%h o=%0b, expected v=%0b d=%h m=%h o=%0b",
                     name, act[17], act[16:9], act[8:1], act[0],
                     expv[17], expv[16:9], expv[8:1], expv[0]);
        end
    endtask

    task automatic drive(input logic en, input logic valid, input logic last,
                         input logic [3:0] data, input logic [2:0] cmd);
        i_en       = en;
        i_valid    = valid;
        i_last     = last;
        i_data_bus = data;
        i_cmd      = cmd;
    endtask

    task automatic beat(input logic en, input logic valid, input logic last,
                        input logic [3:0] data, input logic [2:0] cmd);
        @(posedge clk);
        #1;
        drive(en, valid, last, data, cmd);
        $display("beat en=%0b valid=%0b last=%0b data=%h cmd=%b", en, valid, last, data, cmd);
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, 4'h0, 3'b000);
    endtask

    task automatic lit(input string name, input logic v, input logic [7:0] d,
                       input logic [7:0] m, input logic o);
        @(negedge clk);
        check(name, dut_out, {v, d, m, o});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 3'b000);
        fork
            begin : stimulus
                #3;
                check("reset_state", dut_out, 18'h0);
                #9 rst_n = 1'b1;

                // single beat
                beat(1, 1, 1, 4'hA, 3'b000); idle();
                lit("single", 1'b1, 8'h0A, 8'h0F, 1'b0);

                // two beats
                beat(1, 1, 0, 4'h5, 3'b000);
                beat(1, 1, 1, 4'hC, 3'b111);
                lit("two_mid", 1'b0, 8'h00, 8'h00, 1'b0);
                idle();
                lit("two", 1'b1, 8'hC5, 8'hFF, 1'b0);

                // overlap
                beat(1, 1, 0, 4'hF, 3'b000);
                beat(1, 1, 1, 4'h0, 3'b101); idle();
                lit("overlap", 1'b1, 8'h03, 8'h3F, 1'b1);

                // enable gating
                beat(0, 1, 1, 4'h9, 3'b100); idle();
                lit("en_off", 1'b0, 8'h00, 8'h00, 1'b0);
                beat(1, 1, 1, 4'h9, 3'b100); idle();
                lit("en_on", 1'b1, 8'h12, 8'h1E, 1'b0);

                // i_last without valid is ignored
                beat(1, 0, 1, 4'h5, 3'b000); idle();
                lit("last_no_valid", 1'b0, 8'h00, 8'h00, 1'b0);

                // i_en dropped mid-word, accumulation resumes
                beat(1, 1, 0, 4'h3, 3'b000);
                beat(0, 1, 1, 4'h7, 3'b111);
                beat(1, 1, 1, 4'hA, 3'b111); idle();
                lit("en_resume", 1'b1, 8'hA3, 8'hFF, 1'b0);

                // async reset clears a valid output immediately
                beat(1, 1, 1, 4'hA, 3'b000);
                @(posedge clk);
                #2;
                drive(1'b0, 1'b0, 1'b0, 4'h0, 3'b000);
                rst_n = 1'b0;
                #1;
                check("async_rst", dut_out, 18'h0);
                #1 rst_n = 1'b1;

                // reset mid-word discards the partial word
                beat(1, 1, 0, 4'hF, 3'b000);
                @(posedge clk);
                #2;
                drive(1'b0, 1'b0, 1'b0, 4'h0, 3'b000);
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                beat(1, 1, 1, 4'h3, 3'b100); idle();
                lit("rst_midword", 1'b1, 8'h06, 8'h1E, 1'b0);

                // back-to-back single-beat words
                beat(1, 1, 1, 4'h1, 3'b000);
                beat(1, 1, 1, 4'h2, 3'b101);
                lit("b2b_1", 1'b1, 8'h01, 8'h0F, 1'b0);
                beat(1, 1, 1, 4'h3, 3'b111);
                lit("b2b_2", 1'b1, 8'h08, 8'h3C, 1'b0);
                idle();
                lit("b2b_3", 1'b1, 8'h30, 8'hF0, 1'b0);

                // sweep of two-beat words over every command, checked by the model
                for (int w = 0; w < 8; w++) begin
                    beat(1, 1, 0, 4'(w + 1), 3'(w));
                    beat(1, 1, 1, ~4'(w), 3'(7 - w));
                end
                idle();
                idle();
                idle();
            end
            begin : compare
                forever begin
                    @(negedge clk);
                    if (rst_n) check("model", dut_out, exp_out);
                end
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
